// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the register-file command controller.
// REG_CMD_WR_ACK_EN adds the TX_ACK state used to acknowledge writes.
package reg_cmd_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] DEF_WR_CMD = 8'hAA;
  localparam logic [BYTE_W-1:0] DEF_RD_CMD = 8'hBB;
  localparam logic [BYTE_W-1:0] ACK_BYTE   = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DLO,
    ST_WR_DHI,
    ST_WR_ISSUE,
    ST_RD_ADDR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_TX_LO,
`ifdef REG_CMD_WR_ACK_EN
    ST_TX_HI,
    ST_TX_ACK
`else
    ST_TX_HI
`endif
  } state_e;

  // An address byte is legal only if every bit above the address field is zero.
  function automatic logic addr_in_range(input logic [BYTE_W-1:0] b, input int aw);
    return (b >> aw) == '0;
  endfunction

endpackage

// File: rtl/reg_cmd_tx_sender.sv
// Sends one or two bytes of a word (LSB first) over the TX_D_VLD/TX_BUSY handshake.
// o_done pulses in the cycle whose rising edge accepts the final byte.
module reg_cmd_tx_sender
  import reg_cmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [1:0]          i_nbytes,
  input  logic [2*BYTE_W-1:0] i_word,
  input  logic                i_tx_busy,
  output logic [BYTE_W-1:0]   o_tx_data,
  output logic                o_tx_vld,
  output logic                o_done
);

  logic r_vld;
  logic r_idx;
  logic r_last;
  logic w_accept;

  assign w_accept  = r_vld & ~i_tx_busy;
  assign o_done    = w_accept & (r_idx == r_last);
  assign o_tx_vld  = r_vld;
  // The word is read live: the parent holds it still for the whole transfer.
  assign o_tx_data = r_idx ? i_word[2*BYTE_W-1:BYTE_W] : i_word[BYTE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_idx  <= 1'b0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_idx  <= 1'b0;
      r_last <= (i_nbytes == 2'd2);
    end else if (w_accept) begin
      if (o_done) r_vld <= 1'b0;
      else        r_idx <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Decodes UART write/read frames into register-file strobes; read data goes back LSB first.
// Define REG_CMD_WR_ACK_EN to answer every completed write with the byte ACK_BYTE.
//
// state       | meaning
// IDLE        | waiting for an opcode byte
// WR_ADDR     | waiting for the write address byte
// WR_DLO      | waiting for write data bits 7:0
// WR_DHI      | waiting for write data bits 15:8
// WR_ISSUE    | WrEn high for one cycle
// RD_ADDR     | waiting for the read address byte
// RD_ISSUE    | RdEn high for one cycle
// RD_WAIT     | counting down the register file read latency
// TX_LO/TX_HI | returning read data, low byte then high byte
// TX_ACK      | returning the write acknowledge byte (optional)
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int                DATA_WIDTH = 16,
  parameter int                ADDR_WIDTH = 3,
  parameter logic [BYTE_W-1:0] WR_CMD     = DEF_WR_CMD,
  parameter logic [BYTE_W-1:0] RD_CMD     = DEF_RD_CMD,
  parameter int                RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BYTE_W-1:0]     RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic [BYTE_W-1:0]     TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR,
  output logic                  CTRL_BUSY
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_cmd_err;

  logic       w_addr_ok;
  logic       w_in_busy_state;
  logic       w_rd_done;
  logic       w_tx_load;
  logic [1:0] w_tx_nbytes;
  logic       w_tx_vld;
  logic       w_tx_done;

  assign w_addr_ok   = addr_in_range(RX_P_DATA, ADDR_WIDTH);
  assign w_rd_done   = (r_state == ST_RD_WAIT) && (r_cnt == '0);
  assign w_tx_nbytes = (r_state == ST_RD_WAIT) ? 2'd2 : 2'd1;

`ifdef REG_CMD_WR_ACK_EN
  assign w_tx_load = w_rd_done | (r_state == ST_WR_ISSUE);
`else
  assign w_tx_load = w_rd_done;
`endif

  // Bytes arriving while a strobe or a TX transfer is in flight are dropped with an error.
  always_comb begin
    w_in_busy_state = 1'b0;
    case (r_state)
      ST_WR_ISSUE, ST_RD_ISSUE, ST_RD_WAIT, ST_TX_LO, ST_TX_HI: w_in_busy_state = 1'b1;
`ifdef REG_CMD_WR_ACK_EN
      ST_TX_ACK: w_in_busy_state = 1'b1;
`endif
      default: w_in_busy_state = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_cmd_err <= RX_D_VLD & w_in_busy_state;
      case (r_state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == WR_CMD)      r_state <= ST_WR_ADDR;
            else if (RX_P_DATA == RD_CMD) r_state <= ST_RD_ADDR;
            else                          r_cmd_err <= 1'b1;
          end
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            r_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (!w_addr_ok) begin
              r_cmd_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (r_state == ST_WR_ADDR) begin
              r_state <= ST_WR_DLO;
            end else begin
              r_state <= ST_RD_ISSUE;
              r_rd_en <= 1'b1;
            end
          end
        end
        ST_WR_DLO: begin
          if (RX_D_VLD) begin
            r_wr_data[BYTE_W-1:0] <= RX_P_DATA;
            r_state               <= ST_WR_DHI;
          end
        end
        ST_WR_DHI: begin
          if (RX_D_VLD) begin
            r_wr_data[DATA_WIDTH-1:BYTE_W] <= RX_P_DATA;
            r_state                        <= ST_WR_ISSUE;
            r_wr_en                        <= 1'b1;
          end
        end
`ifdef REG_CMD_WR_ACK_EN
        ST_WR_ISSUE: begin
          r_data  <= DATA_WIDTH'(ACK_BYTE);
          r_state <= ST_TX_ACK;
        end
        ST_TX_ACK: if (w_tx_done) r_state <= ST_IDLE;
`else
        ST_WR_ISSUE: r_state <= ST_IDLE;
`endif
        ST_RD_ISSUE: begin
          r_state <= ST_RD_WAIT;
          r_cnt   <= CNT_W'(RD_LATENCY - 1);
        end
        ST_RD_WAIT: begin
          if (r_cnt == '0) begin
            r_data  <= RdData;
            r_state <= ST_TX_LO;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_TX_LO: if (w_tx_vld && !TX_BUSY) r_state <= ST_TX_HI;
        ST_TX_HI: if (w_tx_done) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  reg_cmd_tx_sender u_tx_sender (
    .clk       (CLK),
    .rst_n     (RST),
    .i_load    (w_tx_load),
    .i_nbytes  (w_tx_nbytes),
    .i_word    (r_data),
    .i_tx_busy (TX_BUSY),
    .o_tx_data (TX_P_DATA),
    .o_tx_vld  (w_tx_vld),
    .o_done    (w_tx_done)
  );

  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign Address   = r_addr;
  assign WrData    = r_wr_data;
  assign TX_D_VLD  = w_tx_vld;
  assign CMD_ERR   = r_cmd_err;
  assign CTRL_BUSY = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Self-checking bench for reg_cmd_ctrl: frame-level model plus directed literal vectors.
// Honors REG_CMD_WR_ACK_EN the same way as the design.
module tb_reg_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        WrEn;
  logic        RdEn;
  logic [2:0]  Address;
  logic [15:0] WrData;
  logic [15:0] RdData;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic        CMD_ERR;
  logic        CTRL_BUSY;

  reg_cmd_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .Address   (Address),
    .WrData    (WrData),
    .RdData    (RdData),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_BUSY   (TX_BUSY),
    .CMD_ERR   (CMD_ERR),
    .CTRL_BUSY (CTRL_BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Register file behind the controller: synchronous write, one-cycle read latency.
  logic [15:0] rf [8];
  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    if (RdEn) RdData <= rf[Address];
  end

  always @(posedge CLK) cyc++;

  // Frame-level model: what each received byte must cause, keyed by cycle.
  logic [15:0] model_mem [8];
  int          m_op;       // 0 none, 1 write frame, 2 read frame
  int          m_cnt;      // bytes after the opcode
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  bit          rd_pending;
  bit          ack_pending;
  int          wr_issue_cyc;
  logic [18:0] exp_wr [int];
  logic [2:0]  exp_rd [int];
  bit          exp_err [int];
  logic [7:0]  txq [$];
  logic [7:0]  tx_log [$];
  logic [18:0] wr_log [$];

  task automatic model_reset();
    m_op = 0; m_cnt = 0; rd_pending = 0; ack_pending = 0; wr_issue_cyc = -1;
    exp_wr.delete(); exp_rd.delete(); exp_err.delete(); txq.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (rd_pending || ack_pending || cyc == wr_issue_cyc) begin
      exp_err[cyc+1] = 1'b1;
    end else if (m_op == 0) begin
      if (b == 8'hAA)      begin m_op = 1; m_cnt = 0; end
      else if (b == 8'hBB) begin m_op = 2; m_cnt = 0; end
      else                 exp_err[cyc+1] = 1'b1;
    end else if (m_cnt == 0) begin
      if (b > 8'd7) begin
        exp_err[cyc+1] = 1'b1;
        m_op = 0;
      end else if (m_op == 2) begin
        exp_rd[cyc+1] = b[2:0];
        txq.push_back(model_mem[b[2:0]][7:0]);
        txq.push_back(model_mem[b[2:0]][15:8]);
        rd_pending = 1;
        m_op = 0;
      end else begin
        m_addr = b[2:0];
        m_cnt  = 1;
      end
    end else if (m_cnt == 1) begin
      m_data[7:0] = b;
      m_cnt = 2;
    end else begin
      m_data[15:8] = b;
      exp_wr[cyc+1] = {m_addr, m_data};
      model_mem[m_addr] = m_data;
      wr_issue_cyc = cyc + 1;
      m_op = 0;
`ifdef REG_CMD_WR_ACK_EN
      txq.push_back(8'h5A);
      ack_pending = 1;
`endif
    end
  endtask

  bit         prev_vld;
  bit         prev_acc;
  logic [7:0] prev_data;

  always @(negedge CLK) begin
    bit          acc;
    logic [18:0] ew;
    if (!RST) begin
      chk("rst_WrEn", WrEn, 0);
      chk("rst_TX_D_VLD", TX_D_VLD, 0);
      chk("rst_CTRL_BUSY", CTRL_BUSY, 0);
      model_reset();
      prev_vld = 0; prev_acc = 0; prev_data = '0;
    end else begin
      chk("WrEn", WrEn, exp_wr.exists(cyc));
      if (exp_wr.exists(cyc)) begin
        ew = exp_wr[cyc];
        chk("wr_Address", Address, ew[18:16]);
        chk("wr_WrData", WrData, ew[15:0]);
      end
      chk("RdEn", RdEn, exp_rd.exists(cyc));
      if (exp_rd.exists(cyc)) chk("rd_Address", Address, exp_rd[cyc]);
      chk("CMD_ERR", CMD_ERR, exp_err.exists(cyc));
      chk("CTRL_BUSY", CTRL_BUSY, (m_op != 0) || rd_pending || ack_pending || (cyc == wr_issue_cyc));
      if (prev_vld && !prev_acc) begin
        chk("tx_hold_vld", TX_D_VLD, 1);
        chk("tx_hold_data", TX_P_DATA, prev_data);
      end
      if (txq.size() == 0) chk("tx_unexpected", TX_D_VLD, 0);
      else if (TX_D_VLD)   chk("tx_data", TX_P_DATA, txq[0]);
      if (WrEn) wr_log.push_back({Address, WrData});
      acc = TX_D_VLD && !TX_BUSY;
      if (RX_D_VLD) model_byte(RX_P_DATA);
      if (acc && txq.size() > 0) begin
        tx_log.push_back(TX_P_DATA);
        void'(txq.pop_front());
        if (txq.size() == 0) begin
          rd_pending  = 0;
          ack_pending = 0;
        end
      end
      prev_vld = TX_D_VLD; prev_acc = acc; prev_data = TX_P_DATA;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (CTRL_BUSY && k < max) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", CTRL_BUSY, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_WrEn"}, WrEn, 0);
    chk({tag, "_RdEn"}, RdEn, 0);
    chk({tag, "_Address"}, Address, 0);
    chk({tag, "_WrData"}, WrData, 0);
    chk({tag, "_TX_P_DATA"}, TX_P_DATA, 0);
    chk({tag, "_TX_D_VLD"}, TX_D_VLD, 0);
    chk({tag, "_CMD_ERR"}, CMD_ERR, 0);
    chk({tag, "_CTRL_BUSY"}, CTRL_BUSY, 0);
  endtask

  initial begin
    int base;
    int n_wr;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; TX_BUSY = 1'b0; RdData = '0;
    for (int i = 0; i < 8; i++) begin
      rf[i]        = 16'hA000 + 16'(i);
      model_mem[i] = 16'hA000 + 16'(i);
    end
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b1;
    tick(2);

    // Write AA,03,34,12
    send(8'hAA); send(8'h03); send(8'h34); send(8'h12);
    chk("s1_WrEn", WrEn, 1);
    chk("s1_Address", Address, 3);
    chk("s1_WrData", WrData, 16'h1234);
    chk("s1_CMD_ERR", CMD_ERR, 0);
    tick(1);
    chk("s1_WrEn_off", WrEn, 0);
    wait_idle(20);

    // Read back address 3, then a back-to-back read of untouched address 5
    base = tx_log.size();
    send(8'hBB); send(8'h03);
    chk("s2_RdEn", RdEn, 1);
    wait_idle(50);
    chk("s2_tx_count", tx_log.size(), base + 2);
    chk("s2_tx0", tx_log[base], 8'h34);
    chk("s2_tx1", tx_log[base+1], 8'h12);
    base = tx_log.size();
    send(8'hBB); send(8'h05);
    wait_idle(50);
    chk("s2b_tx0", tx_log[base], 8'h05);
    chk("s2b_tx1", tx_log[base+1], 8'hA0);

    // TX stage busy for 20 cycles
    TX_BUSY = 1'b1;
    base = tx_log.size();
    send(8'hBB); send(8'h03);
    tick(20);
    chk("s3_vld_held", TX_D_VLD, 1);
    chk("s3_data_held", TX_P_DATA, 8'h34);
    chk("s3_busy", CTRL_BUSY, 1);
    TX_BUSY = 1'b0;
    tick(1);
    chk("s3_first_accept", tx_log.size(), base + 1);
    wait_idle(50);
    chk("s3_tx_count", tx_log.size(), base + 2);
    chk("s3_tx1", tx_log[base+1], 8'h12);

    // Bad opcode and bad addresses
    n_wr = wr_log.size();
    send(8'h7F);
    chk("s4_err_opcode", CMD_ERR, 1);
    tick(1);
    chk("s4_err_pulse_end", CMD_ERR, 0);
    send(8'hAA); send(8'h09);
    chk("s4_err_wr_addr", CMD_ERR, 1);
    tick(1);
    chk("s4_idle", CTRL_BUSY, 0);
    send(8'hBB); send(8'hF0);
    chk("s4_err_rd_addr", CMD_ERR, 1);
    tick(2);
    chk("s4_no_write", wr_log.size(), n_wr);
    send(8'hAA); send(8'h05); send(8'hCD); send(8'hAB);
    wait_idle(20);
    chk("s4_write_ok", wr_log[$], {3'd5, 16'hABCD});

    // Stray byte while TX_LO is waiting
    TX_BUSY = 1'b1;
    base = tx_log.size();
    send(8'hBB); send(8'h05);
    tick(5);
    send(8'h55);
    chk("s5_err_stray", CMD_ERR, 1);
    TX_BUSY = 1'b0;
    wait_idle(50);
    chk("s5_tx_count", tx_log.size(), base + 2);
    chk("s5_tx0", tx_log[base], 8'hCD);
    chk("s5_tx1", tx_log[base+1], 8'hAB);

    // Reset in the middle of a write frame
    n_wr = wr_log.size();
    send(8'hAA); send(8'h02); send(8'hFF);
    RST = 1'b0;
    tick(2);
    chk_all_zero("midrst");
    RST = 1'b1;
    tick(3);
    chk("s6_no_write", wr_log.size(), n_wr);
    send(8'hAA); send(8'h02); send(8'h00); send(8'h00);
    wait_idle(20);
    chk("s6_write_zero", wr_log[$], {3'd2, 16'h0000});
    base = tx_log.size();
    send(8'hBB); send(8'h02);
    wait_idle(50);
    chk("s6_tx_count", tx_log.size(), base + 2);
    chk("s6_tx0", tx_log[base], 8'h00);
    chk("s6_tx1", tx_log[base+1], 8'h00);

    // Write acknowledge traffic
    base = tx_log.size();
    send(8'hAA); send(8'h01); send(8'h78); send(8'h56);
    wait_idle(20);
    chk("s7_write", wr_log[$], {3'd1, 16'h5678});
`ifdef REG_CMD_WR_ACK_EN
    chk("s7_ack_count", tx_log.size(), base + 1);
    chk("s7_ack_byte", tx_log[base], 8'h5A);
`else
    chk("s7_no_tx", tx_log.size(), base);
`endif
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
